key_onehot_capture: RTL

Front-end stage that feeds the 4-to-2 encoder. It synchronizes and debounces four raw push-button inputs and tracks press/release with a small state machine. It drives the encoder's one-hot `x[3:0]` and `en` inputs with clean, latched values. Multi-key presses are rejected and flagged instead of being passed through as non-one-hot codes.

---
 rtl/key_onehot_capture.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/key_onehot_capture.sv
// Synchronizes and debounces four push-buttons and latches a clean one-hot code for the 4-to-2 encoder.
// Latency: a key_in change reaches the outputs DB_CYCLES+4 clocks later. There is no backpressure; clr is a level.
module key_onehot_capture #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       clr,
  output logic [3:0] x,
  output logic       en,
  output logic       valid,
  output logic       multi_err
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HELD     = 3'd1,
    RELEASED = 3'd2,
    MULTI    = 3'd3,
    WAIT     = 3'd4
  } state_t;

  logic [3:0]    s1;
  logic [3:0]    k_sync;
  logic [3:0]    k_last;
  logic [3:0]    k_stb;
  logic [CW-1:0] cnt;
  state_t        state;

  logic key_none;
  logic key_one;
  logic key_many;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      k_sync <= '0;
      k_last <= '0;
      k_stb  <= '0;
      cnt    <= '0;
    end else begin
      s1     <= key_in;
      k_sync <= s1;
      k_last <= k_sync;
      // Any movement of k_sync restarts the stability count.
      if (k_sync == k_stb) begin
        cnt <= '0;
      end else if (k_sync != k_last) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        k_stb <= k_sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign key_none = (k_stb == 4'b0000);
  assign key_one  = !key_none && ((k_stb & (k_stb - 4'd1)) == 4'b0000);
  assign key_many = !key_none && !key_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      en        <= 1'b0;
      valid     <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr && state != MULTI) begin
        x     <= '0;
        en    <= 1'b0;
        state <= key_none ? IDLE : WAIT;
      end else begin
        case (state)
          IDLE: begin
            if (key_one) begin
              state <= HELD;
              x     <= k_stb;
              en    <= 1'b1;
              valid <= 1'b1;
            end else if (key_many) begin
              state     <= MULTI;
              x         <= '0;
              en        <= 1'b0;
              multi_err <= 1'b1;
            end
          end
          HELD: begin
            if (key_none) begin
              state <= RELEASED;
            end else if (key_many) begin
              state     <= MULTI;
              x         <= '0;
              en        <= 1'b0;
              multi_err <= 1'b1;
            end
          end
          RELEASED: begin
            // A fresh press is a new capture even when it repeats the previous key.
            if (key_one) begin
              state <= HELD;
              x     <= k_stb;
              en    <= 1'b1;
              valid <= 1'b1;
            end else if (key_many) begin
              state     <= MULTI;
              x         <= '0;
              en        <= 1'b0;
              multi_err <= 1'b1;
            end
          end
          MULTI: begin
            x  <= '0;
            en <= 1'b0;
            if (key_none) begin
              state     <= IDLE;
              multi_err <= 1'b0;
            end else begin
              multi_err <= 1'b1;
            end
          end
          WAIT: begin
            if (key_none) begin
              state <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            x         <= '0;
            en        <= 1'b0;
            multi_err <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
